// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if: SPI pins, channel samples and register/status outputs of the ADC SPI responder.
//   sclk, cs_n, mosi : SPI master -> responder (asynchronous to clk)
//   miso             : responder -> SPI master
//   ch0..ch3         : 13-bit sample values for addresses 00..11
//   ctrl_reg         : last written control word
//   range_reg        : last written range word
//   frame_done       : one-clk pulse, valid 16-bit frame finished
//   frame_err        : one-clk pulse, frame ended with a bad bit count
interface adc_spi_responder_if;
   logic        sclk, cs_n, mosi, miso;
   logic [12:0] ch0, ch1, ch2, ch3;
   logic [12:0] ctrl_reg, range_reg;
   logic        frame_done, frame_err;
   modport master (output sclk, cs_n, mosi, ch0, ch1, ch2, ch3,
                   input  miso, ctrl_reg, range_reg, frame_done, frame_err);
   modport slave  (input  sclk, cs_n, mosi, ch0, ch1, ch2, ch3,
                   output miso, ctrl_reg, range_reg, frame_done, frame_err);
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI mode-0 slave that streams ADC channel samples and accepts control/range writes.
//   clk : system clock, the only clock
//   rst : synchronous active-low reset
//   bus : adc_spi_responder_if.slave (SPI pins, ch0..ch3, ctrl_reg, range_reg, frame_done, frame_err)
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rst,
   adc_spi_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;
   state_t                 state_q, state_d;
   // sclk/cs_n chains carry one extra flop that holds the previous synchronized level
   logic [SYNC_STAGES:0]   sclk_q, cs_q, vld_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic [15:0]            tx_q, tx_d, rx_q, rx_d;
   logic [4:0]             bitcnt_q, bitcnt_d;
   logic [1:0]             ptr_q, ptr_d;
   logic [12:0]            ctrl_q, ctrl_d, range_q, range_d, ch_sel;
   logic                   ovr_q, ovr_d, done_q, done_d, err_q, err_d;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

   assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
   assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
   assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
   // a cs_n that was already low across reset only looks like a fall while the
   // chain still holds its reset value; vld_q masks that window
   assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES] & vld_q[SYNC_STAGES];
   assign mosi_s    = mosi_q[SYNC_STAGES-1];
   assign ch_sel    = ptr_q[1] ? (ptr_q[0] ? bus.ch3 : bus.ch2) : (ptr_q[0] ? bus.ch1 : bus.ch0);

   assign bus.miso       = (state_q != IDLE) & tx_q[15];
   assign bus.ctrl_reg   = ctrl_q;
   assign bus.range_reg  = range_q;
   assign bus.frame_done = done_q;
   assign bus.frame_err  = err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sclk_q   <= '0;
         cs_q     <= '1;
         mosi_q   <= '0;
         vld_q    <= '0;
         state_q  <= IDLE;
         tx_q     <= '0;
         rx_q     <= '0;
         bitcnt_q <= '0;
         ptr_q    <= '0;
         ctrl_q   <= 13'h1800;
         range_q  <= '0;
         ovr_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sclk_q   <= {sclk_q[SYNC_STAGES-1:0], bus.sclk};
         cs_q     <= {cs_q[SYNC_STAGES-1:0], bus.cs_n};
         mosi_q   <= SYNC_STAGES'({mosi_q, bus.mosi});
         vld_q    <= {vld_q[SYNC_STAGES-1:0], 1'b1};
         state_q  <= state_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         bitcnt_q <= bitcnt_d;
         ptr_q    <= ptr_d;
         ctrl_q   <= ctrl_d;
         range_q  <= range_d;
         ovr_q    <= ovr_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      bitcnt_d = bitcnt_q;
      ptr_d    = ptr_q;
      ctrl_d   = ctrl_q;
      range_d  = range_q;
      ovr_d    = ovr_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            rx_d     = '0;
            bitcnt_d = '0;
            ovr_d    = 1'b0;
            if (cs_fall) begin
               state_d = SHIFT;
               tx_d    = {1'b0, ptr_q, ch_sel};
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (sclk_fall) begin
               tx_d = {tx_q[14:0], 1'b0};
            end else if (sclk_rise) begin
               rx_d     = {rx_q[14:0], mosi_s};
               bitcnt_d = bitcnt_q + 5'd1;
               state_d  = (bitcnt_q == 5'd15) ? WAIT_CS : SHIFT;
            end
         end
         WAIT_CS: begin
            if (cs_rise) begin
               state_d = IDLE;
               err_d   = ovr_q;
               done_d  = ~ovr_q;
               if (!ovr_q) begin
                  ctrl_d  = (rx_q[15:13] == 3'b100) ? rx_q[12:0] : ctrl_q;
                  range_d = (rx_q[15:13] == 3'b101) ? rx_q[12:0] : range_q;
                  // a control write restarts the channel sequence
                  ptr_d   = (rx_q[15:13] == 3'b100 || ptr_q >= ctrl_q[12:11]) ? 2'd0 : ptr_q + 2'd1;
               end
            end else if (sclk_rise) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: randomized and directed SPI frames against a frame-level reference model.
module tb_adc_spi_responder;
   localparam int H = 8;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] chv [4];
   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   logic [12:0] m_ctrl = 13'h1800;
   logic [12:0] m_range = 13'h0000;
   int          m_ptr = 0;
   logic [15:0] got, w;

   adc_spi_responder_if bus ();
   assign bus.ch0 = chv[0];
   assign bus.ch1 = chv[1];
   assign bus.ch2 = chv[2];
   assign bus.ch3 = chv[3];

   adc_spi_responder #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #50 clk = ~clk;

   always @(negedge clk) begin
      if (bus.frame_done) done_cnt++;
      if (bus.frame_err) err_cnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_frame(input logic [15:0] word);
      if (word[15:13] == 3'b100) begin
         m_ctrl = word[12:0];
         m_ptr  = 0;
      end else begin
         if (word[15:13] == 3'b101) m_range = word[12:0];
         m_ptr = (m_ptr >= int'(m_ctrl[12:11])) ? 0 : m_ptr + 1;
      end
   endfunction

   task automatic xfer(input logic [15:0] word, input int nbits, input bit drop_cs,
                       input bit scramble, output logic [15:0] rd);
      rd = '0;
      @(negedge clk);
      bus.cs_n = 1'b0;
      repeat (H) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = (i < 16) ? word[15-i] : 1'b0;
         repeat (H) @(negedge clk);
         if (i < 16) rd[15-i] = bus.miso;
         bus.sclk = 1'b1;
         if (scramble && i == 8) for (int k = 0; k < 4; k++) chv[k] = 13'($urandom);
         repeat (H) @(negedge clk);
         bus.sclk = 1'b0;
      end
      if (drop_cs) begin
         repeat (H) @(negedge clk);
         bus.cs_n = 1'b1;
         repeat (12) @(negedge clk);
      end
   endtask

   task automatic full(input string tag, input logic [15:0] word, input bit scramble,
                       output logic [15:0] rd);
      logic [15:0] exp;
      int d0, e0;
      exp = {1'b0, 2'(m_ptr), chv[m_ptr]};
      d0 = done_cnt;
      e0 = err_cnt;
      xfer(word, 16, 1'b1, scramble, rd);
      model_frame(word);
      check({tag, "_miso"}, rd, exp);
      check({tag, "_done"}, 16'(done_cnt - d0), 16'd1);
      check({tag, "_err"}, 16'(err_cnt - e0), 16'd0);
      check({tag, "_ctrl"}, {3'b0, bus.ctrl_reg}, {3'b0, m_ctrl});
      check({tag, "_range"}, {3'b0, bus.range_reg}, {3'b0, m_range});
   endtask

   task automatic bad_frame(input string tag, input logic [15:0] word, input int nbits);
      int d0, e0;
      logic [15:0] rd;
      d0 = done_cnt;
      e0 = err_cnt;
      xfer(word, nbits, 1'b1, 1'b0, rd);
      check({tag, "_err"}, 16'(err_cnt - e0), 16'd1);
      check({tag, "_done"}, 16'(done_cnt - d0), 16'd0);
      check({tag, "_ctrl"}, {3'b0, bus.ctrl_reg}, {3'b0, m_ctrl});
      check({tag, "_range"}, {3'b0, bus.range_reg}, {3'b0, m_range});
   endtask

   initial begin
      int d0, e0;
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      chv[0] = 13'h0ABC;
      chv[1] = 13'h1111;
      chv[2] = 13'h0222;
      chv[3] = 13'h1333;
      repeat (5) @(negedge clk);
      check("rst_miso", {15'b0, bus.miso}, 16'h0);
      check("rst_ctrl", {3'b0, bus.ctrl_reg}, 16'h1800);
      check("rst_range", {3'b0, bus.range_reg}, 16'h0000);
      check("rst_done", {15'b0, bus.frame_done}, 16'h0);
      check("rst_err", {15'b0, bus.frame_err}, 16'h0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      full("read0", 16'h0000, 1'b0, got);
      check("read0_lit", got, 16'h0ABC);

      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < 4; k++) chv[k] = 13'($urandom);
         w = 16'($urandom);
         if (w[15:14] == 2'b10) w[15] = 1'b0;
         full("rnd_read", w, n[0], got);
      end

      full("ctrl_wr", 16'h8800, 1'b0, got);
      check("ctrl_lit", {3'b0, bus.ctrl_reg}, 16'h0800);
      full("seq_a", 16'h0000, 1'b0, got);
      check("seq_a_addr", {14'b0, got[14:13]}, 16'd0);
      full("seq_b", 16'h0000, 1'b0, got);
      check("seq_b_addr", {14'b0, got[14:13]}, 16'd1);
      full("seq_c", 16'h0000, 1'b0, got);
      check("seq_c_addr", {14'b0, got[14:13]}, 16'd0);

      full("range_wr", 16'hAAA0, 1'b0, got);
      check("range_lit", {3'b0, bus.range_reg}, 16'h0AA0);
      check("range_ctrl", {3'b0, bus.ctrl_reg}, 16'h0800);

      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 4; k++) chv[k] = 13'($urandom);
         w = 16'($urandom);
         if (n % 3 == 0) w[15:13] = 3'b100;
         if (n % 3 == 1) w[15:13] = 3'b101;
         full("rnd_mix", w, 1'b1, got);
      end

      bad_frame("short", 16'h8FFF, 9);
      full("after_short", 16'h0000, 1'b0, got);
      bad_frame("overrun", 16'hBFFF, 17);
      full("after_ovr", 16'h0000, 1'b0, got);

      d0 = done_cnt;
      e0 = err_cnt;
      xfer(16'h9234, 7, 1'b0, 1'b0, got);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_miso", {15'b0, bus.miso}, 16'h0);
      check("mid_rst_ctrl", {3'b0, bus.ctrl_reg}, 16'h1800);
      check("mid_rst_range", {3'b0, bus.range_reg}, 16'h0000);
      check("mid_rst_done", {15'b0, bus.frame_done}, 16'h0);
      check("mid_rst_err", {15'b0, bus.frame_err}, 16'h0);
      rst = 1'b1;
      m_ctrl = 13'h1800;
      m_range = 13'h0000;
      m_ptr = 0;
      repeat (6) @(negedge clk);
      bus.cs_n = 1'b1;
      repeat (12) @(negedge clk);
      check("mid_rst_no_done", 16'(done_cnt - d0), 16'd0);
      check("mid_rst_no_err", 16'(err_cnt - e0), 16'd0);
      full("after_rst", 16'h0000, 1'b0, got);
      full("after_rst2", 16'h0000, 1'b0, got);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flops synchronizing sclk, cs_n and mosi into clk.
REQ-002 SHALL have port clk  input  1  system clock (10 MHz), the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk and active-low.
REQ-004 SHALL have port sclk  input  1  SPI clock from the master, asynchronous to clk.
REQ-005 SHALL have port cs_n  input  1  SPI chip select from the master, active-low, asynchronous.
REQ-006 SHALL have port mosi  input  1  SPI data from the master.
REQ-007 SHALL have port miso  output  1  SPI data to the master.
REQ-008 SHALL have ports ch0..ch3  input  13 each  sample values for address 00 (v_o), 01 (temp), 10 (i_in) and 11 (v_i).
REQ-009 SHALL have port ctrl_reg  output  13  last written control word.
REQ-010 SHALL have port range_reg  output  13  last written range word.
REQ-011 SHALL have port frame_done  output  1  one-clk pulse when a valid 16-bit frame completes.
REQ-012 SHALL have port frame_err  output  1  one-clk pulse when a frame ends with a bit count other than 16.

Function
REQ-013 SHALL use SPI mode 0, MSB first, 16-bit frames: mosi is sampled on the sclk rising edge and miso changes on the sclk falling edge.
REQ-014 SHALL do all edge detection on synchronized signals; sclk frequency SHALL be no more than clk/8.
REQ-015 SHALL use states IDLE, SHIFT and WAIT_CS; SHALL move IDLE->SHIFT on a cs_n fall.
REQ-016 On entering SHIFT, SHALL latch tx = {1'b0, ptr[1:0], ch[ptr]} and drive tx[15] on miso within 1 clk.
REQ-017 In SHIFT, on each sclk fall SHALL shift tx left and drive the next bit on miso.
REQ-018 In SHIFT, on each sclk rise SHALL shift mosi into rx and increment bitcnt (5 bits).
REQ-019 When bitcnt reaches 16, SHALL move SHIFT->WAIT_CS.
REQ-020 In WAIT_CS, extra sclk rises SHALL NOT change rx and SHALL set an overrun flag.
REQ-021 On a cs_n rise in WAIT_CS without overrun, SHALL pulse frame_done, apply the rx decode, advance ptr and return to IDLE.
REQ-022 On a cs_n rise in SHIFT, or in WAIT_CS with overrun, SHALL pulse frame_err, discard rx, leave ptr unchanged and return to IDLE.
REQ-023 rx decode: if rx[15:13]==3'b100, ctrl_reg SHALL take rx[12:0].
REQ-024 rx decode: if rx[15:13]==3'b101, range_reg SHALL take rx[12:0].
REQ-025 rx decode: any other rx value SHALL be a read-only frame with no register change.
REQ-026 Channel sequencing: seq_last = ctrl_reg[12:11]; ptr SHALL advance to ptr+1, or wrap to 0 when ptr >= seq_last.
REQ-027 A control write SHALL also force ptr to 0, taking precedence over the advance in REQ-026.
REQ-028 miso SHALL be 0 whenever the state is IDLE.
REQ-029 ch0..ch3 changing mid-frame SHALL NOT affect the bits being shifted out.
REQ-030 If cs_n falls while already in SHIFT or WAIT_CS, SHALL treat it as already low and take no action.

Reset
REQ-031 While rst==0 at a clk edge: state SHALL be IDLE, and miso, frame_done, frame_err, bitcnt, ptr, tx and rx SHALL be 0.
REQ-032 While rst==0 at a clk edge: ctrl_reg SHALL be 13'h1800 (seq_last=3) and range_reg SHALL be 13'h0000.
REQ-033 All synchronizer flops SHALL reset to idle levels: cs_n=1, sclk=0, mosi=0.
REQ-034 After reset release, a new frame SHALL start only after cs_n has been seen high and then falling; reset asserted mid-frame SHALL abort the frame with no frame_done or frame_err pulse.

Verification
REQ-035 Bench SHALL check read frame: ch0=13'h0ABC, ptr=0, mosi=0 for 16 bits -> miso shows 16'h0ABC and frame_done pulses once.
REQ-036 Bench SHALL check control write: mosi=16'h8800 -> ctrl_reg=13'h0800 (seq_last=1) and ptr=0; the next two reads return addresses 00 then 01, and the third read returns 00 again.
REQ-037 Bench SHALL check range write: mosi=16'hAAA0 -> range_reg=13'h0AA0, ctrl_reg unchanged.
REQ-038 Bench SHALL check short frame: cs_n rises after 9 sclk -> frame_err pulse, ptr and registers unchanged, and the next full frame reads the same channel.
REQ-039 Bench SHALL check overrun: 17 sclk in one frame -> frame_err pulse and no register write.
REQ-040 Bench SHALL check reset mid-frame: rst=0 at bit 7 -> all outputs at reset values, no pulse, and a following full frame completes normally.
